div_issue_queue: RTL and testbench



---
 rtl/div_issue_queue_pkg.sv | 23 ++
 rtl/div_issue_queue_fifo_ctrl.sv | 54 +++++
 rtl/div_issue_queue.sv | 107 ++++++++++
 tb/tb_div_issue_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_queue_pkg.sv
// Shared types for the divide issue queue: FSM state and the queued uop record.
package div_issue_queue_pkg;

  localparam int unsigned MWidth       = 32;
  localparam int unsigned LgRobEntries = 6;
  localparam int unsigned LgPrfEntries = 7;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_START,
    Q_BUSY
  } q_state_t;

  typedef struct packed {
    logic [MWidth-1:0]       srcA;
    logic [MWidth-1:0]       srcB;
    logic [LgRobEntries-1:0] rob_ptr;
    logic [LgPrfEntries-1:0] prf_ptr;
    logic                    is_signed;
    logic                    is_rem;
  } div_uop_t;

endpackage

// File: rtl/div_issue_queue_fifo_ctrl.sv
// Head/tail/count bookkeeping for a power-of-two circular buffer with synchronous clear.
module div_issue_queue_fifo_ctrl #(
  parameter int unsigned LgN = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           push_i,
  input  logic           pop_i,
  output logic [LgN-1:0] head_o,
  output logic [LgN-1:0] tail_o,
  output logic [LgN:0]   count_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam logic [LgN:0] Depth = (LgN+1)'(1) << LgN;

  logic [LgN-1:0] head_q, head_d;
  logic [LgN-1:0] tail_q, tail_d;
  logic [LgN:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == Depth);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/div_issue_queue.sv
// In-order queue of pending divide uops feeding an iterative divider one op at a time.
module div_issue_queue
  import div_issue_queue_pkg::*;
#(
  parameter int unsigned LG_N = 2,
  parameter int unsigned W    = MWidth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_rdy,
  input  logic [W-1:0]            enq_srcA,
  input  logic [W-1:0]            enq_srcB,
  input  logic [LgRobEntries-1:0] enq_rob_ptr,
  input  logic [LgPrfEntries-1:0] enq_prf_ptr,
  input  logic                    enq_is_signed,
  input  logic                    enq_is_rem,
  input  logic                    div_complete,
  output logic                    start_div,
  output logic [W-1:0]            inA,
  output logic [W-1:0]            inB,
  output logic [LgRobEntries-1:0] rob_ptr_out,
  output logic [LgPrfEntries-1:0] prf_ptr_out,
  output logic                    is_signed_div,
  output logic                    is_rem,
  output logic [LG_N:0]           occupancy,
  output logic                    busy
);

  localparam int unsigned N = 1 << LG_N;

  logic [LG_N-1:0] head, tail;
  logic [LG_N:0]   count;
  logic            full, empty;
  logic            push, pop;

  q_state_t state_q;
  div_uop_t out_q;
  div_uop_t enq_uop;
  div_uop_t mem_q [N];

  // No bypass: a pop this cycle does not open a slot for this cycle's enqueue.
  assign push = enq_valid & ~full & ~flush;
  assign pop  = (state_q == Q_IDLE) & ~empty & ~flush;

  assign enq_uop = '{
    srcA:      enq_srcA,
    srcB:      enq_srcB,
    rob_ptr:   enq_rob_ptr,
    prf_ptr:   enq_prf_ptr,
    is_signed: enq_is_signed,
    is_rem:    enq_is_rem
  };

  div_issue_queue_fifo_ctrl #(
    .LgN(LG_N)
  ) u_fifo_ctrl (
    .clk_i  (clk),
    .rst_ni (reset),
    .clear_i(flush),
    .push_i (push),
    .pop_i  (pop),
    .head_o (head),
    .tail_o (tail),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[tail] <= enq_uop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= Q_IDLE;
      out_q   <= '0;
    end else begin
      case (state_q)
        Q_IDLE: begin
          if (pop) begin
            out_q   <= mem_q[head];
            state_q <= Q_START;
          end
        end
        // A flush here drops the popped uop before the divider ever sees it.
        Q_START: state_q <= flush ? Q_IDLE : Q_BUSY;
        // Flush does not abort an in-flight divide; the ROB squashes its result.
        Q_BUSY:  if (div_complete) state_q <= Q_IDLE;
        default: state_q <= Q_IDLE;
      endcase
    end
  end

  assign start_div     = (state_q == Q_START) & ~flush;
  assign inA           = out_q.srcA;
  assign inB           = out_q.srcB;
  assign rob_ptr_out   = out_q.rob_ptr;
  assign prf_ptr_out   = out_q.prf_ptr;
  assign is_signed_div = out_q.is_signed;
  assign is_rem        = out_q.is_rem;
  assign occupancy     = count;
  assign enq_rdy       = ~full;
  assign busy          = (state_q != Q_IDLE) | ~empty;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed and randomized checks of div_issue_queue against a queue-based behavioural model.
module tb_div_issue_queue;
  import div_issue_queue_pkg::*;

  localparam int unsigned W  = MWidth;
  localparam int unsigned LR = LgRobEntries;
  localparam int unsigned LP = LgPrfEntries;
  localparam int unsigned N  = 4;

  logic          clk, reset, flush, enq_valid, enq_rdy;
  logic [W-1:0]  enq_srcA, enq_srcB, inA, inB;
  logic [LR-1:0] enq_rob_ptr, rob_ptr_out;
  logic [LP-1:0] enq_prf_ptr, prf_ptr_out;
  logic          enq_is_signed, enq_is_rem, div_complete, start_div;
  logic          is_signed_div, is_rem, busy;
  logic [2:0]    occupancy;

  div_issue_queue #(
    .LG_N(2),
    .W   (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_rdy      (enq_rdy),
    .enq_srcA     (enq_srcA),
    .enq_srcB     (enq_srcB),
    .enq_rob_ptr  (enq_rob_ptr),
    .enq_prf_ptr  (enq_prf_ptr),
    .enq_is_signed(enq_is_signed),
    .enq_is_rem   (enq_is_rem),
    .div_complete (div_complete),
    .start_div    (start_div),
    .inA          (inA),
    .inB          (inB),
    .rob_ptr_out  (rob_ptr_out),
    .prf_ptr_out  (prf_ptr_out),
    .is_signed_div(is_signed_div),
    .is_rem       (is_rem),
    .occupancy    (occupancy),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [LR-1:0] rob;
    logic [LP-1:0] prf;
    logic          s;
    logic          r;
  } m_uop_t;

  int     checks, failures;
  m_uop_t mq[$];
  m_uop_t cur;
  int     phase;  // 0: no uop issued, 1: start pulse cycle, 2: waiting for divider
  int     issued[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check this cycle's outputs at the negedge, advance the model, then step past the posedge.
  task automatic cyc();
    m_uop_t in_u;
    bit     do_pop, do_enq;
    @(negedge clk);
    chk("start_div", start_div, (phase == 1) && !flush);
    chk("enq_rdy", enq_rdy, mq.size() < N);
    chk("occupancy", occupancy, mq.size());
    chk("busy", busy, (phase != 0) || (mq.size() != 0));
    chk("inA", inA, cur.a);
    chk("inB", inB, cur.b);
    chk("rob_ptr_out", rob_ptr_out, cur.rob);
    chk("prf_ptr_out", prf_ptr_out, cur.prf);
    chk("is_signed_div", is_signed_div, cur.s);
    chk("is_rem", is_rem, cur.r);
    if (start_div === 1'b1) issued.push_back(int'(rob_ptr_out));
    in_u = '{a: enq_srcA, b: enq_srcB, rob: enq_rob_ptr, prf: enq_prf_ptr,
             s: enq_is_signed, r: enq_is_rem};
    if (!reset) begin
      mq.delete();
      cur   = '0;
      phase = 0;
    end else begin
      do_pop = (phase == 0) && (mq.size() > 0) && !flush;
      do_enq = enq_valid && (mq.size() < N) && !flush;
      case (phase)
        0: if (do_pop) phase = 1;
        1: phase = flush ? 0 : 2;
        default: if (div_complete) phase = 0;
      endcase
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) cur = mq.pop_front();
        if (do_enq) mq.push_back(in_u);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input int tag, input int a, input int b, input bit s, input bit r);
    enq_valid     = 1'b1;
    enq_rob_ptr   = LR'(tag);
    enq_prf_ptr   = LP'(tag + 6);
    enq_srcA      = W'(a);
    enq_srcB      = W'(b);
    enq_is_signed = s;
    enq_is_rem    = r;
  endtask

  // Enqueue one uop into an idle, empty queue and run until it occupies the divider.
  task automatic occupy_divider(input int tag);
    set_enq(tag, tag * 3, 5, 1'b1, 1'b0);
    cyc();
    enq_valid = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    checks = 0; failures = 0;
    phase = 0; cur = '0;
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; div_complete = 1'b0;
    enq_srcA = '0; enq_srcB = '0; enq_rob_ptr = '0; enq_prf_ptr = '0;
    enq_is_signed = 1'b0; enq_is_rem = 1'b0;

    // Reset held for two edges
    @(posedge clk);
    #1;
    cyc();
    #1;
    chk("rst_start_div", start_div, 0);
    chk("rst_enq_rdy", enq_rdy, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // Single op: enqueue at cycle 0, start at cycle 2
    enq_valid = 1'b1; enq_rob_ptr = 3; enq_prf_ptr = 9;
    enq_srcA = 100; enq_srcB = 7; enq_is_signed = 0; enq_is_rem = 0;
    cyc();
    enq_valid = 1'b0;
    #1 chk("single_c1_start", start_div, 0);
    cyc();
    #1;
    chk("single_c2_start", start_div, 1);
    chk("single_inA", inA, 100);
    chk("single_inB", inB, 7);
    chk("single_rob", rob_ptr_out, 3);
    chk("single_prf", prf_ptr_out, 9);
    cyc();
    repeat (3) cyc();
    #1;
    chk("single_hold_inA", inA, 100);
    chk("single_hold_start", start_div, 0);
    chk("single_hold_busy", busy, 1);
    div_complete = 1'b1;
    cyc();
    div_complete = 1'b0;
    #1 chk("single_done_busy", busy, 0);
    cyc();

    // Fill and backpressure while the divider is busy
    occupy_divider(20);
    for (int i = 0; i < 5; i++) begin
      set_enq(10 + i, 1000 + i, 3 + i, i[0], i[1]);
      cyc();
    end
    enq_valid = 1'b0;
    #1;
    chk("fill_enq_rdy", enq_rdy, 0);
    chk("fill_occupancy", occupancy, 4);
    for (int i = 0; i < 4; i++) begin
      div_complete = 1'b1;
      cyc();
      div_complete = 1'b0;
      #1 chk("b2b_gap", start_div, 0);
      cyc();
      #1;
      chk("b2b_start", start_div, 1);
      chk("b2b_order", rob_ptr_out, 10 + i);
      cyc();
    end
    div_complete = 1'b1;
    cyc();
    div_complete = 1'b0;
    repeat (3) begin
      #1 chk("fill_no_fifth", start_div, 0);
      cyc();
    end

    // Wrap-around: ten uops through the ring, issued strictly in order
    issued.delete();
    for (int i = 0; i < 10; i++) begin
      set_enq(i, 7 * i, i + 1, 1'b0, 1'b1);
      cyc();
      enq_valid = 1'b0;
      cyc();
      cyc();
      div_complete = 1'b1;
      cyc();
      div_complete = 1'b0;
    end
    chk("wrap_count", issued.size(), 10);
    for (int i = 0; i < 10 && i < issued.size(); i++) chk("wrap_tag", issued[i], i);

    // Flush while in Q_START with three entries still queued
    occupy_divider(30);
    for (int i = 0; i < 4; i++) begin
      set_enq(31 + i, 50 + i, 2, 1'b0, 1'b0);
      cyc();
    end
    enq_valid = 1'b0;
    div_complete = 1'b1;
    cyc();
    div_complete = 1'b0;
    cyc();
    #1 chk("flush_pre_occ", occupancy, 3);
    flush = 1'b1;
    #1 chk("flush_start_div", start_div, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_occ", occupancy, 0);
    chk("flush_busy", busy, 0);
    repeat (4) begin
      #1 chk("flush_no_start", start_div, 0);
      cyc();
    end

    // Enqueue and flush in the same cycle
    set_enq(40, 1, 1, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    enq_valid = 1'b0;
    #1 chk("enqflush_occ", occupancy, 0);
    cyc();

    // Enqueue and pop in the same cycle with two entries queued
    occupy_divider(50);
    for (int i = 0; i < 2; i++) begin
      set_enq(51 + i, 9, 4, 1'b1, 1'b1);
      cyc();
    end
    enq_valid = 1'b0;
    div_complete = 1'b1;
    cyc();
    div_complete = 1'b0;
    set_enq(53, 9, 4, 1'b0, 1'b0);
    #1 chk("enqpop_pre_occ", occupancy, 2);
    cyc();
    enq_valid = 1'b0;
    #1;
    chk("enqpop_occ", occupancy, 2);
    chk("enqpop_start", start_div, 1);
    chk("enqpop_tag", rob_ptr_out, 51);

    // Randomized traffic, including mid-operation resets and spurious completes
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 99) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      enq_valid     = $urandom_range(0, 1) == 1;
      enq_srcA      = W'($urandom);
      enq_srcB      = W'($urandom);
      enq_rob_ptr   = LR'($urandom);
      enq_prf_ptr   = LP'($urandom);
      enq_is_signed = $urandom_range(0, 1) == 1;
      enq_is_rem    = $urandom_range(0, 1) == 1;
      div_complete  = (phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      cyc();
    end
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; div_complete = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
